fetch_stage: RTL and testbench

//  Instruction fetch front end. Holds the PC and issues one word per cycle to a fixed-latency instruction memory.

---
 rtl/ooo_pkg.sv | 21 ++
 rtl/fetch_stage_if.sv | 32 +++
 rtl/fetch_buffer.sv | 66 ++++++
 rtl/fetch_stage.sv | 101 ++++++++++
 tb/tb_fetch_stage.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ooo_pkg.sv
// ooo_pkg: types and constants shared by the fetch front end.
//   word_t         32-bit machine word
//   fetch_entry_t  {instr, pc} pair held in the fetch output buffer
//   INSTR_BYTES    instruction size in bytes (PC increment)
//   word_align()   clears the byte-offset bits of an address
package ooo_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t instr;
    word_t pc;
  } fetch_entry_t;

  localparam int unsigned INSTR_BYTES = 4;

  function automatic word_t word_align(input word_t addr);
    return addr & ~word_t'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: bus signals between the fetch stage, the instruction
// memory, branch resolution and the decoder.
//   master : fetch stage side (drives imem request and decoder outputs)
//   slave  : environment side (memory, back end, decoder)
//   o_imem_req/o_imem_addr   fetch request and word address
//   i_imem_rdata             instruction word, one cycle after the request
//   i_redirect_valid/_pc     redirect from branch resolution
//   o_valid/o_instruction/o_pc/i_ready  decoder handshake
interface fetch_stage_if;
  import ooo_pkg::*;

  logic  o_imem_req;
  word_t o_imem_addr;
  word_t i_imem_rdata;
  logic  i_redirect_valid;
  word_t i_redirect_pc;
  logic  o_valid;
  word_t o_instruction;
  word_t o_pc;
  logic  i_ready;

  modport master (
    output o_imem_req, o_imem_addr, o_valid, o_instruction, o_pc,
    input  i_imem_rdata, i_redirect_valid, i_redirect_pc, i_ready
  );

  modport slave (
    input  o_imem_req, o_imem_addr, o_valid, o_instruction, o_pc,
    output i_imem_rdata, i_redirect_valid, i_redirect_pc, i_ready
  );

endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry FIFO of fetch_entry_t feeding the decoder.
//   clk, rst_n   clock, synchronous active-low reset
//   push/push_data  write one entry (caller guarantees not full)
//   pop          remove head (ignored when empty)
//   flush        discard all entries; has priority over push and pop
//   valid/head   head entry, driven straight from a register
//   occ          current occupancy (0..2)
// A simultaneous push and pop retires the head first, then appends.
module fetch_buffer
  import ooo_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic         valid,
  output fetch_entry_t head,
  output logic [1:0]   occ
);

  fetch_entry_t slot0_q;
  fetch_entry_t slot1_q;
  logic [1:0]   occ_q;
  logic         do_pop;

  assign do_pop = pop && (occ_q != 2'd0);

  // slot0_q is always the head, so the decoder sees registered data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q   <= 2'd0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else if (flush) begin
      occ_q <= 2'd0;
    end else begin
      case ({push, do_pop})
        2'b10: begin
          if (occ_q == 2'd0) slot0_q <= push_data;
          else               slot1_q <= push_data;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          slot0_q <= slot1_q;
          occ_q   <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            slot0_q <= push_data;
          end else begin
            slot0_q <= slot1_q;
            slot1_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid = (occ_q != 2'd0);
  assign head  = slot0_q;
  assign occ   = occ_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end.
// Holds the PC, issues one word per cycle to a fixed 1-cycle-latency
// instruction memory, buffers responses in fetch_buffer and presents
// {instruction, pc} to the decoder. Redirects flush all wrong-path state.
//   clk, rst_n      clock, synchronous active-low reset
//   fif (master)    imem request/response, redirect, decoder handshake
//   o_stall_cycles  cycles with o_valid && !i_ready (saturating), only
//                   present when FETCH_STALL_CNT_EN is defined
// Parameters: RESET_PC (4-byte aligned), BUF_DEPTH (must be 2).
module fetch_stage
  import ooo_pkg::*;
#(
  parameter word_t RESET_PC  = 32'h0000_0000,
  parameter int    BUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master fif
`ifdef FETCH_STALL_CNT_EN
  ,
  output word_t         o_stall_cycles
`endif
);

  if (BUF_DEPTH != 2) begin : g_bad_depth
    $error("fetch_stage: BUF_DEPTH must be 2");
  end
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("fetch_stage: RESET_PC must be 4-byte aligned");
  end

  word_t        pc_q;
  word_t        req_pc_q;
  logic         inflight_q;
  logic [1:0]   occ;
  logic [2:0]   credits;
  logic         pop;
  logic         issue;
  logic         push;
  fetch_entry_t head;
  fetch_entry_t push_data;

  assign pop     = fif.o_valid && fif.i_ready;
  assign credits = {1'b0, occ} + {2'b00, inflight_q};

  // Buffered plus in-flight words never exceed the buffer size; a pop in
  // the same cycle frees the slot the new response will need.
  assign issue = rst_n && !fif.i_redirect_valid && ((credits < 3'd2) || pop);
  assign push  = inflight_q && !fif.i_redirect_valid;

  assign push_data = '{instr: fif.i_imem_rdata, pc: req_pc_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
    end else if (fif.i_redirect_valid) begin
      pc_q       <= word_align(fif.i_redirect_pc);
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        req_pc_q <= pc_q;
        pc_q     <= pc_q + word_t'(INSTR_BYTES);
      end
    end
  end

  fetch_buffer u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (fif.i_redirect_valid),
    .valid     (fif.o_valid),
    .head      (head),
    .occ       (occ)
  );

  assign fif.o_imem_req    = issue;
  assign fif.o_imem_addr   = pc_q;
  assign fif.o_instruction = head.instr;
  assign fif.o_pc          = head.pc;

`ifdef FETCH_STALL_CNT_EN
  word_t stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (fif.o_valid && !fif.i_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign o_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: self-checking bench for fetch_stage.
// Directed table, hand sequences for redirect/wrap/reset corners, then a
// randomized run checked against a transaction-level model.
module tb_fetch_stage;
  import ooo_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if fif ();

`ifdef FETCH_STALL_CNT_EN
  word_t stall_cycles;
`endif

  fetch_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fif   (fif)
`ifdef FETCH_STALL_CNT_EN
    ,
    .o_stall_cycles (stall_cycles)
`endif
  );

  int checks = 0;
  int errors = 0;

  function automatic word_t memf(input word_t a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Instruction memory: data one cycle after the request, junk otherwise
  always @(posedge clk)
    fif.i_imem_rdata <= fif.o_imem_req ? memf(fif.o_imem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input bit rdy, input bit rv, input word_t rpc);
    fif.i_ready          = rdy;
    fif.i_redirect_valid = rv;
    fif.i_redirect_pc    = rpc;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 32'h0);
    repeat (2) next_cycle();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit    rdy;
    bit    rv;
    word_t rpc;
    bit    req;
    word_t addr;
    bit    valid;
    word_t pc;
  } vec_t;

  vec_t tbl[23];

  typedef struct {
    word_t pc;
    int    cyc;
  } pend_t;

  pend_t q[$];

  initial begin
    word_t wrap_addr[5];
    word_t wrap_pc[5];

    tbl[0]  = '{1, 0, 32'h0,   1, 32'h000, 0, 32'h0};
    tbl[1]  = '{1, 0, 32'h0,   1, 32'h004, 0, 32'h0};
    tbl[2]  = '{1, 0, 32'h0,   1, 32'h008, 1, 32'h000};
    tbl[3]  = '{1, 0, 32'h0,   1, 32'h00C, 1, 32'h004};
    tbl[4]  = '{0, 0, 32'h0,   0, 32'h010, 1, 32'h008};
    tbl[5]  = '{0, 0, 32'h0,   0, 32'h010, 1, 32'h008};
    tbl[6]  = '{1, 1, 32'h100, 0, 32'h010, 1, 32'h008};
    tbl[7]  = '{1, 0, 32'h0,   1, 32'h100, 0, 32'h0};
    tbl[8]  = '{1, 0, 32'h0,   1, 32'h104, 0, 32'h0};
    tbl[9]  = '{1, 0, 32'h0,   1, 32'h108, 1, 32'h100};
    tbl[10] = '{1, 1, 32'h203, 0, 32'h10C, 1, 32'h104};
    tbl[11] = '{1, 0, 32'h0,   1, 32'h200, 0, 32'h0};
    tbl[12] = '{1, 0, 32'h0,   1, 32'h204, 0, 32'h0};
    tbl[13] = '{1, 0, 32'h0,   1, 32'h208, 1, 32'h200};
    tbl[14] = '{0, 0, 32'h0,   0, 32'h20C, 1, 32'h204};
    tbl[15] = '{0, 0, 32'h0,   0, 32'h20C, 1, 32'h204};
    tbl[16] = '{0, 0, 32'h0,   0, 32'h20C, 1, 32'h204};
    tbl[17] = '{0, 0, 32'h0,   0, 32'h20C, 1, 32'h204};
    tbl[18] = '{0, 0, 32'h0,   0, 32'h20C, 1, 32'h204};
    tbl[19] = '{1, 0, 32'h0,   1, 32'h20C, 1, 32'h204};
    tbl[20] = '{1, 0, 32'h0,   1, 32'h210, 1, 32'h208};
    tbl[21] = '{1, 0, 32'h0,   1, 32'h214, 1, 32'h20C};
    tbl[22] = '{1, 0, 32'h0,   1, 32'h218, 1, 32'h210};

    wrap_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0, 32'h0};
    wrap_pc   = '{32'h0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

    drive(1'b1, 1'b0, 32'h0);
    #1;
    do_reset();

    // directed table: startup, stall, redirects, unaligned target
    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
      @(negedge clk);
      chk($sformatf("tbl%0d req", i), 32'(fif.o_imem_req), 32'(tbl[i].req));
      chk($sformatf("tbl%0d addr", i), fif.o_imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d valid", i), 32'(fif.o_valid), 32'(tbl[i].valid));
      if (tbl[i].valid) begin
        chk($sformatf("tbl%0d pc", i), fif.o_pc, tbl[i].pc);
        chk($sformatf("tbl%0d instr", i), fif.o_instruction, memf(tbl[i].pc));
      end
      next_cycle();
    end

    // address wrap
    drive(1'b1, 1'b1, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("wrap redirect req", 32'(fif.o_imem_req), 32'd0);
    next_cycle();
    drive(1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 3) begin
        chk($sformatf("wrap%0d req", k), 32'(fif.o_imem_req), 32'd1);
        chk($sformatf("wrap%0d addr", k), fif.o_imem_addr, wrap_addr[k]);
      end
      if (k >= 2) begin
        chk($sformatf("wrap%0d valid", k), 32'(fif.o_valid), 32'd1);
        chk($sformatf("wrap%0d pc", k), fif.o_pc, wrap_pc[k]);
      end
      next_cycle();
    end

    // redirect during reset is ignored; in-flight response discarded
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 32'h300);
    @(negedge clk);
    chk("rst req", 32'(fif.o_imem_req), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rst valid", 32'(fif.o_valid), 32'd0);
    chk("rst req2", 32'(fif.o_imem_req), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("post-rst addr0", fif.o_imem_addr, 32'h0);
    chk("post-rst req0", 32'(fif.o_imem_req), 32'd1);
    chk("post-rst valid0", 32'(fif.o_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("post-rst addr1", fif.o_imem_addr, 32'h4);
    chk("post-rst valid1", 32'(fif.o_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("post-rst valid2", 32'(fif.o_valid), 32'd1);
    chk("post-rst pc2", fif.o_pc, 32'h0);
    chk("post-rst instr2", fif.o_instruction, memf(32'h0));
    next_cycle();

`ifdef FETCH_STALL_CNT_EN
    do_reset();
    drive(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("stall cnt reset", stall_cycles, 32'd0);
    next_cycle();
    repeat (4) next_cycle();
    drive(1'b1, 1'b0, 32'h0);
    repeat (2) next_cycle();
    @(negedge clk);
    chk("stall cnt 3", stall_cycles, 32'd3);
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("stall cnt cleared", stall_cycles, 32'd0);
    next_cycle();
    rst_n = 1'b1;
`endif

    // randomized run against a transaction-level model: every issued
    // address is remembered with its issue cycle until it is delivered
    do_reset();
    begin
      word_t exp_addr;
      int    now;
      bit    rdy, rv, valid_exp, pop_exp, req_exp;
      word_t rpc;
      exp_addr = 32'h0;
      now      = 0;
      q.delete();
      for (int n = 0; n < 800; n++) begin
        rdy = ($urandom_range(0, 3) != 0);
        rv  = ($urandom_range(0, 15) == 0);
        rpc = $urandom();
        if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
        drive(rdy, rv, rpc);
        @(negedge clk);
        valid_exp = (q.size() > 0) && (q[0].cyc + 2 <= now);
        pop_exp   = valid_exp && rdy;
        req_exp   = !rv && ((q.size() < 2) || pop_exp);
        chk("rnd req", 32'(fif.o_imem_req), 32'(req_exp));
        chk("rnd addr", fif.o_imem_addr, exp_addr);
        chk("rnd valid", 32'(fif.o_valid), 32'(valid_exp));
        if (valid_exp) begin
          chk("rnd pc", fif.o_pc, q[0].pc);
          chk("rnd instr", fif.o_instruction, memf(q[0].pc));
        end
        if (pop_exp) void'(q.pop_front());
        if (rv) begin
          q.delete();
          exp_addr = rpc & 32'hFFFF_FFFC;
        end else if (req_exp) begin
          q.push_back('{exp_addr, now});
          exp_addr = exp_addr + 32'd4;
        end
        now++;
        next_cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
